mem_protect_arbiter: RTL and testbench
======================================

# mem_protect_arbiter

Sequencing controller for the memory protection path. Arbitrates two requesters onto one shared memory port and owns the lockable protection bitmap. Checks every granted write against that bitmap, forwards allowed accesses with a valid/ready handshake, and drops blocked ones while logging them. It sits between the bus masters and the memory, and replaces free-running combinational write gating with a registered, arbitrated access path.

## Interface
- n, 8: address width; also bitmap size (one protect bit per address 0..n-1)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset synchronous and active-low
- req0_valid / req1_valid  in  1  request pending; held with addr/we until matching ready
- req0_addr / req1_addr  in  n  request address
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_ready / req1_ready  out  1  one-cycle completion pulse to the granted requester
- mem_valid  out  1  memory access in progress
- mem_ready  in  1  memory accepts the access this cycle
- mem_addr  out  n  latched address
- mem_rd  out  1  read strobe, qualified by mem_valid
- mem_wr  out  1  write strobe, qualified by mem_valid
- cfg_we  in  1  load bitmap from cfg_prot (ignored when locked)
- cfg_prot  in  n  new bitmap value
- cfg_lock  in  1  set lock; sticky until reset
- prot_map  out  n  current bitmap
- locked  out  1  lock status
- viol  out  1  sticky violation flag
- viol_addr  out  n  address of most recent violation
- viol_src  out  1  requester index of most recent violation
- viol_count  out  8  violation count, saturates at 255
- viol_clr  in  1  clear viol and viol_count

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE: arbitrate among the valid requests.
  - With one valid request, grant it.
  - With both valid, grant the requester not granted last (round-robin). After reset, last-granted = 1, so req0 wins the first tie.
  - On grant, latch idx, addr and we, and evaluate the check once.
  - Blocked = we && (addr >= n || prot_map[addr]).
  - Allowed → ISSUE. Blocked → DONE, with the violation logged at the same edge.
- ISSUE: mem_valid=1, mem_rd=!we, mem_wr=we. Hold until mem_ready=1, then → DONE.
- DONE: granted req_ready=1 for one cycle, then → IDLE. A new grant is possible in the following IDLE cycle.
- Reads are never blocked. Bitmap or lock changes after the grant do not affect the access in flight.
- Config:
  - cfg_we && !locked loads prot_map at the next edge.
  - cfg_we and cfg_lock in the same cycle: the map loads and the lock sets.
  - Once locked=1, cfg_we is ignored.
- Violation log: sets viol, captures viol_addr and viol_src, and increments viol_count (saturating at 255).
  - viol_clr clears viol and viol_count; viol_addr and viol_src hold.
  - Violation and viol_clr in the same cycle: viol=1, viol_count=1.

## Timing
- Reset values:
  - state IDLE; all ready outputs, mem_valid, mem_rd, mem_wr = 0
  - mem_addr = 0; prot_map = all ones (everything write-protected); locked = 0
  - viol = 0, viol_addr = 0, viol_src = 0, viol_count = 0
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Allowed access with mem_ready already high: valid sampled at edge 0; mem_valid at cycles 1..; req_ready at cycle 2. Minimum valid-to-ready latency is 2 cycles.
- Each mem_ready-low cycle in ISSUE adds one cycle. mem_addr, mem_rd and mem_wr are stable while mem_valid=1.
- Blocked write: req_ready at cycle 1. mem_valid never asserts. The viol outputs update at cycle 1.
- Exactly one ready pulse per grant. A requester may drop valid in the cycle after its ready.
- Synchronous reset mid-transaction: next edge returns to IDLE with reset values. No ready pulse; the memory access is abandoned.
- Bitmap writes take effect for grants made at the edge after the cfg_we edge.

## Test plan
- Reset, then write req0 addr 3 → blocked (prot_map=0xFF): req0_ready at cycle 1, mem_valid stays 0, viol=1, viol_addr=3, viol_count=1.
- cfg_we with cfg_prot=0x0F, then req1 write addr 5 with mem_ready held low 3 cycles → mem_valid for 4 cycles with mem_wr=1 and mem_addr=5; req1_ready one cycle after mem_ready.
- Both requesters valid continuously (reads) → grants alternate req0, req1, req0, …; each ready pulse is followed by an IDLE cycle.
- cfg_prot=0x00 with cfg_lock=1, then cfg_we with 0xFF → prot_map stays 0x00, locked=1; write to addr 7 completes with mem_wr=1.
- Write to addr 9 with n=8 → blocked as out-of-range. Then 256 more blocked writes → viol_count saturates at 255. viol_clr in the same cycle as a violation → viol_count=1.
- rst_n low during ISSUE → next cycle mem_valid=0, no ready pulse, prot_map=0xFF, locked=0.

Source files
------------

// File: rtl/mem_protect_arbiter.sv
// mem_protect_arbiter: round-robin arbiter for two requesters with a lockable write-protect bitmap
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req{0,1}_valid/addr/we     requests, held until the matching ready
//   req{0,1}_ready             one-cycle completion pulse to the granted requester
//   mem_valid/addr/rd/wr       registered memory access, mem_ready completes it
//   cfg_we/cfg_prot/cfg_lock   bitmap load and sticky lock
//   prot_map, locked           current bitmap and lock status
//   viol/viol_addr/viol_src/viol_count, viol_clr   violation log
module mem_protect_arbiter #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [n-1:0] req0_addr,
    input  logic         req0_we,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [n-1:0] req1_addr,
    input  logic         req1_we,
    output logic         req1_ready,
    output logic         mem_valid,
    input  logic         mem_ready,
    output logic [n-1:0] mem_addr,
    output logic         mem_rd,
    output logic         mem_wr,
    input  logic         cfg_we,
    input  logic [n-1:0] cfg_prot,
    input  logic         cfg_lock,
    output logic [n-1:0] prot_map,
    output logic         locked,
    output logic         viol,
    output logic [n-1:0] viol_addr,
    output logic         viol_src,
    output logic [7:0]   viol_count,
    input  logic         viol_clr
);
    localparam int aw = $clog2(n);
    localparam logic [n-1:0] lim = n[n-1:0];

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    state_t state, nxt;

    logic last, idx, we_q, gnt, grant, blocked, sel_we, n_idx, n_we;
    logic [n-1:0] sel_addr;

    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        gnt      = (req0_valid && req1_valid) ? !last : req1_valid;
        sel_addr = gnt ? req1_addr : req0_addr;
        sel_we   = gnt ? req1_we : req0_we;
        // out-of-range addresses have no protect bit and are always write-protected
        blocked  = sel_we && (sel_addr >= lim || prot_map[sel_addr[aw-1:0]]);
        grant    = (state == IDLE) && (req0_valid || req1_valid);
        nxt      = state;
        n_idx    = idx;
        n_we     = we_q;
        case (state)
            IDLE: if (grant) begin
                nxt   = blocked ? DONE : ISSUE;
                n_idx = gnt;
                n_we  = sel_we;
            end
            ISSUE:   nxt = mem_ready ? DONE : ISSUE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // outputs are registered from the next-state decode so they line up with the state register
    always_ff @(posedge clk)
        if (!rst_n) begin
            last       <= 1'b1;
            idx        <= 1'b0;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_valid  <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            prot_map   <= '1;
            locked     <= 1'b0;
            viol       <= 1'b0;
            viol_addr  <= '0;
            viol_src   <= 1'b0;
            viol_count <= 8'd0;
        end else begin
            idx        <= n_idx;
            we_q       <= n_we;
            mem_valid  <= nxt == ISSUE;
            mem_rd     <= nxt == ISSUE && !n_we;
            mem_wr     <= nxt == ISSUE && n_we;
            req0_ready <= nxt == DONE && !n_idx;
            req1_ready <= nxt == DONE && n_idx;
            if (grant) begin
                last     <= gnt;
                mem_addr <= sel_addr;
            end
            if (cfg_we && !locked) prot_map <= cfg_prot;
            if (cfg_lock) locked <= 1'b1;
            // a violation on the clear cycle wins and counts as the first one after clearing
            if (grant && blocked) begin
                viol       <= 1'b1;
                viol_addr  <= sel_addr;
                viol_src   <= gnt;
                viol_count <= viol_clr ? 8'd1 : (viol_count == 8'hff ? 8'hff : viol_count + 8'd1);
            end else if (viol_clr) begin
                viol       <= 1'b0;
                viol_count <= 8'd0;
            end
        end
endmodule

// File: tb/tb_mem_protect_arbiter.sv
// tb_mem_protect_arbiter: directed self-checking bench for mem_protect_arbiter
module tb_mem_protect_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_we, req0_ready;
    logic       req1_valid, req1_we, req1_ready;
    logic [7:0] req0_addr, req1_addr;
    logic       mem_valid, mem_ready, mem_rd, mem_wr;
    logic [7:0] mem_addr;
    logic       cfg_we, cfg_lock, locked;
    logic [7:0] cfg_prot, prot_map;
    logic       viol, viol_src, viol_clr;
    logic [7:0] viol_addr, viol_count;

    int n_vec = 0;
    int n_err = 0;

    mem_protect_arbiter #(.n(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_we(req0_we), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_we(req1_we), .req1_ready(req1_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .cfg_we(cfg_we), .cfg_prot(cfg_prot), .cfg_lock(cfg_lock),
        .prot_map(prot_map), .locked(locked),
        .viol(viol), .viol_addr(viol_addr), .viol_src(viol_src), .viol_count(viol_count), .viol_clr(viol_clr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 0; req0_valid = 0; req0_addr = 0; req0_we = 0;
        req1_valid = 0; req1_addr = 0; req1_we = 0; mem_ready = 0;
        cfg_we = 0; cfg_prot = 0; cfg_lock = 0; viol_clr = 0;
        tick; tick;
        rst_n = 1;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        chk("rst_prot_map", prot_map, 8'hff);
        chk("rst_locked", locked, 0);
        chk("rst_viol", viol, 0);
        chk("rst_viol_count", viol_count, 0);
        chk("rst_mem_addr", mem_addr, 0);
        // blocked write, req0 addr 3
        req0_valid = 1; req0_addr = 3; req0_we = 1;
        tick;
        chk("blk_req0_ready", req0_ready, 1);
        chk("blk_mem_valid", mem_valid, 0);
        chk("blk_viol", viol, 1);
        chk("blk_viol_addr", viol_addr, 3);
        chk("blk_viol_src", viol_src, 0);
        chk("blk_viol_count", viol_count, 1);
        req0_valid = 0;
        tick;
        chk("blk_ready_drop", req0_ready, 0);
        // load map 0x0F, req1 write addr 5 with mem_ready low for 3 cycles
        cfg_we = 1; cfg_prot = 8'h0f;
        tick;
        cfg_we = 0;
        chk("cfg_prot_map", prot_map, 8'h0f);
        req1_valid = 1; req1_addr = 5; req1_we = 1; mem_ready = 0;
        for (int c = 1; c <= 4; c++) begin
            tick;
            chk("wr5_mem_valid", mem_valid, 1);
            chk("wr5_mem_wr", {mem_wr, mem_rd}, 2'b10);
            chk("wr5_mem_addr", mem_addr, 5);
            chk("wr5_no_ready", req1_ready, 0);
            if (c == 4) mem_ready = 1;
        end
        tick;
        chk("wr5_req1_ready", req1_ready, 1);
        chk("wr5_mem_valid_off", mem_valid, 0);
        req1_valid = 0;
        tick;
        chk("wr5_ready_drop", req1_ready, 0);
        // both requesters reading continuously: round-robin
        req0_valid = 1; req0_we = 0; req0_addr = 1;
        req1_valid = 1; req1_we = 0; req1_addr = 2;
        for (int g = 0; g < 4; g++) begin
            tick;
            chk("rr_mem_valid", mem_valid, 1);
            chk("rr_mem_rd", {mem_rd, mem_wr}, 2'b10);
            chk("rr_mem_addr", mem_addr, (g % 2 == 0) ? 1 : 2);
            tick;
            chk("rr_ready", {req0_ready, req1_ready}, (g % 2 == 0) ? 2'b10 : 2'b01);
            tick;
            chk("rr_idle_ready", {req0_ready, req1_ready}, 2'b00);
            chk("rr_idle_mem_valid", mem_valid, 0);
        end
        req0_valid = 0; req1_valid = 0;
        tick;
        // load 0x00 with lock, then an ignored load of 0xFF
        cfg_we = 1; cfg_prot = 8'h00; cfg_lock = 1;
        tick;
        cfg_prot = 8'hff; cfg_lock = 0;
        tick;
        cfg_we = 0;
        chk("lock_prot_map", prot_map, 8'h00);
        chk("lock_locked", locked, 1);
        req0_valid = 1; req0_addr = 7; req0_we = 1;
        tick;
        chk("wr7_mem", {mem_valid, mem_wr, mem_rd}, 3'b110);
        chk("wr7_mem_addr", mem_addr, 7);
        tick;
        chk("wr7_ready", req0_ready, 1);
        chk("wr7_viol_count", viol_count, 1);
        req0_valid = 0;
        tick;
        // out-of-range write, then saturation
        req1_valid = 1; req1_addr = 9; req1_we = 1;
        tick;
        chk("oor_ready", req1_ready, 1);
        chk("oor_mem_valid", mem_valid, 0);
        chk("oor_viol_addr", viol_addr, 9);
        chk("oor_viol_src", viol_src, 1);
        chk("oor_viol_count", viol_count, 2);
        for (int k = 1; k <= 256; k++) begin
            tick;
            tick;
            if (k == 100) chk("sat_count_102", viol_count, 102);
            if (k == 253) chk("sat_count_255", viol_count, 255);
        end
        chk("sat_count_final", viol_count, 255);
        chk("sat_ready", req1_ready, 1);
        tick;
        viol_clr = 1;
        tick;
        viol_clr = 0;
        chk("clr_viol_same", viol, 1);
        chk("clr_count_same", viol_count, 1);
        req1_valid = 0;
        tick;
        viol_clr = 1;
        tick;
        viol_clr = 0;
        chk("clr_viol", viol, 0);
        chk("clr_count", viol_count, 0);
        chk("clr_addr_hold", viol_addr, 9);
        chk("clr_src_hold", viol_src, 1);
        // reset during ISSUE
        req0_valid = 1; req0_addr = 4; req0_we = 0; mem_ready = 0;
        tick;
        chk("mid_mem_valid", mem_valid, 1);
        rst_n = 0;
        tick;
        chk("mid_rst_mem_valid", mem_valid, 0);
        chk("mid_rst_ready", {req0_ready, req1_ready}, 0);
        chk("mid_rst_prot_map", prot_map, 8'hff);
        chk("mid_rst_locked", locked, 0);
        rst_n = 1; req0_valid = 0;
        tick;
        chk("post_rst_ready", {req0_ready, req1_ready}, 0);
        chk("post_rst_mem_valid", mem_valid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
